// File: rtl/egg_spawn_scheduler.sv
`timescale 1ns/1ps
// egg_spawn_scheduler
// Schedules egg respawns for NUM_SLOTS egg sprite slots sharing one spawn
// datapath. Tracks live/pending slots, counts a per-slot respawn delay in
// frames, round-robin grants ready slots, picks a platform (avoiding ones
// already occupied by live eggs) and an x position on it, then offers the
// spawn over a valid/ready handshake.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   frame_tick_i   one-cycle pulse per video frame
//   collect_i      per-slot pulse: yoshi collected that slot's egg
//   spawn_ready_i  sprite units accept the offered spawn
//   spawn_valid_o  spawn offer present
//   spawn_slot_o   slot being spawned
//   spawn_x_o      egg x (upper-left)
//   spawn_y_o      egg y (upper-left)
//   spawn_type_o   egg type code
//   active_o       per-slot live egg flags
module egg_spawn_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 frame_tick_i,
    input  logic [NUM_SLOTS-1:0] collect_i,
    input  logic                 spawn_ready_i,
    output logic                 spawn_valid_o,
    output logic [2:0]           spawn_slot_o,
    output logic [9:0]           spawn_x_o,
    output logic [9:0]           spawn_y_o,
    output logic [5:0]           spawn_type_o,
    output logic [NUM_SLOTS-1:0] active_o
);

    localparam logic [5:0] RESPAWN_LOAD = 6'(RESPAWN_FRAMES);
    localparam logic [2:0] LAST_SLOT    = 3'(NUM_SLOTS - 1);
    localparam logic [7:0] LFSR_SEED    = 8'hA5;

    typedef enum logic [1:0] {ST_IDLE, ST_PICK, ST_CHECK, ST_OFFER} state_e;

    function automatic logic [9:0] plat_lo(input logic [2:0] p);
        case (p)
            3'd0:    plat_lo = 10'd16;
            3'd1:    plat_lo = 10'd480;
            3'd2:    plat_lo = 10'd80;
            3'd3:    plat_lo = 10'd16;
            3'd4:    plat_lo = 10'd384;
            3'd5:    plat_lo = 10'd112;
            default: plat_lo = 10'd16;
        endcase
    endfunction

    function automatic logic [9:0] plat_hi(input logic [2:0] p);
        case (p)
            3'd0:    plat_hi = 10'd144;
            3'd1:    plat_hi = 10'd608;
            3'd2:    plat_hi = 10'd545;
            3'd3:    plat_hi = 10'd240;
            3'd4:    plat_hi = 10'd608;
            3'd5:    plat_hi = 10'd513;
            default: plat_hi = 10'd608;
        endcase
    endfunction

    function automatic logic [9:0] plat_y(input logic [2:0] p);
        case (p)
            3'd0:    plat_y = 10'd116;
            3'd1:    plat_y = 10'd116;
            3'd2:    plat_y = 10'd199;
            3'd3:    plat_y = 10'd282;
            3'd4:    plat_y = 10'd282;
            3'd5:    plat_y = 10'd365;
            default: plat_y = 10'd448;
        endcase
    endfunction

    // Overflowing offsets fold back from the right edge by off[6:0]; every
    // platform spans at least 128 pixels so the fold never passes lo.
    function automatic logic [9:0] calc_x(input logic [9:0] lo, input logic [9:0] hi,
                                          input logic [9:0] off);
        logic [10:0] s;
        s = {1'b0, lo} + {1'b0, off};
        if (s > {1'b0, hi}) begin
            calc_x = hi - {3'b000, off[6:0]};
        end else begin
            calc_x = s[9:0];
        end
    endfunction

    state_e                state_q, state_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic [9:0]            pos_cnt_q, pos_cnt_d;
    logic [NUM_SLOTS-1:0]  active_q, active_d;
    logic [NUM_SLOTS-1:0]  pending_q, pending_d;
    logic [5:0]            cnt_q [NUM_SLOTS];
    logic [5:0]            cnt_d [NUM_SLOTS];
    logic [2:0]            slot_plat_q [NUM_SLOTS];
    logic [2:0]            slot_plat_d [NUM_SLOTS];
    logic [2:0]            last_q, last_d;
    logic [2:0]            slot_q, slot_d;
    logic [2:0]            plat_q, plat_d;
    logic [9:0]            off_q, off_d;
    logic [5:0]            type_q, type_d;
    logic [2:0]            tries_q, tries_d;
    logic                  valid_q, valid_d;
    logic [9:0]            x_q, x_d;
    logic [9:0]            y_q, y_d;

    logic [NUM_SLOTS-1:0]  ready_s;
    logic                  hs_s;
    logic                  grant_found_s;
    logic [2:0]            grant_slot_s;
    logic                  conflict_s;

    assign hs_s = valid_q & spawn_ready_i;

    // Per-slot ready flags: pending with the respawn delay fully counted down.
    always_comb begin
        ready_s = '0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            ready_s[j] = pending_q[j] && (cnt_q[j] == 6'd0);
        end
    end

    // Round-robin search starting at the slot after the last grant.
    always_comb begin
        grant_found_s = 1'b0;
        grant_slot_s  = 3'd0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (!grant_found_s && ready_s[j] &&
                    ((int'(last_q) + k == j) || (int'(last_q) + k == j + NUM_SLOTS))) begin
                    grant_found_s = 1'b1;
                    grant_slot_s  = 3'(j);
                end else begin
                    grant_found_s = grant_found_s;
                end
            end
        end
    end

    // Platform already occupied by some live egg.
    always_comb begin
        conflict_s = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (active_q[j] && (slot_plat_q[j] == plat_q)) begin
                conflict_s = 1'b1;
            end else begin
                conflict_s = conflict_s;
            end
        end
    end

    // Slot bookkeeping: collects, handshake completion and frame countdowns.
    // A collect in the same cycle as a frame tick loads without decrementing.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        slot_plat_d = slot_plat_q;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (collect_i[j] && active_q[j]) begin
                active_d[j]  = 1'b0;
                pending_d[j] = 1'b1;
                cnt_d[j]     = RESPAWN_LOAD;
            end else if (hs_s && (slot_q == 3'(j))) begin
                active_d[j]    = 1'b1;
                pending_d[j]   = 1'b0;
                slot_plat_d[j] = plat_q;
            end else if (frame_tick_i && pending_q[j] && (cnt_q[j] != 6'd0)) begin
                cnt_d[j] = cnt_q[j] - 6'd1;
            end else begin
                cnt_d[j] = cnt_q[j];
            end
        end
    end

    // Free-running random sources.
    always_comb begin
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        pos_cnt_d = pos_cnt_q + 10'd1;
    end

    // Spawn FSM next state and datapath.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        slot_d  = slot_q;
        plat_d  = plat_q;
        off_d   = off_q;
        type_d  = type_q;
        tries_d = tries_q;
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    slot_d  = grant_slot_s;
                    state_d = ST_PICK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PICK: begin
                plat_d  = (lfsr_q[2:0] == 3'd7) ? 3'd6 : lfsr_q[2:0];
                off_d   = pos_cnt_q;
                type_d  = pos_cnt_q[5:0];
                tries_d = 3'd0;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (conflict_s && (tries_q < 3'd6)) begin
                    plat_d  = (plat_q == 3'd6) ? 3'd0 : plat_q + 3'd1;
                    tries_d = tries_q + 3'd1;
                end else begin
                    x_d     = calc_x(plat_lo(plat_q), plat_hi(plat_q), off_q);
                    y_d     = plat_y(plat_q);
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (spawn_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = slot_q;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            pos_cnt_q <= 10'd0;
            active_q  <= '0;
            pending_q <= '1;
            for (int j = 0; j < NUM_SLOTS; j++) begin
                cnt_q[j]       <= 6'd0;
                slot_plat_q[j] <= 3'd0;
            end
            last_q    <= LAST_SLOT;
            slot_q    <= 3'd0;
            plat_q    <= 3'd0;
            off_q     <= 10'd0;
            type_q    <= 6'd0;
            tries_q   <= 3'd0;
            valid_q   <= 1'b0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pos_cnt_q   <= pos_cnt_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            slot_plat_q <= slot_plat_d;
            last_q      <= last_d;
            slot_q      <= slot_d;
            plat_q      <= plat_d;
            off_q       <= off_d;
            type_q      <= type_d;
            tries_q     <= tries_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign spawn_valid_o = valid_q;
    assign spawn_slot_o  = slot_q;
    assign spawn_x_o     = x_q;
    assign spawn_y_o     = y_q;
    assign spawn_type_o  = type_q;
    assign active_o      = active_q;

endmodule

// File: doc/egg_spawn_scheduler.md
# egg_spawn_scheduler

Sequences egg respawns for up to NUM_SLOTS egg sprite instances sharing one spawn datapath. It tracks which slots hold a live egg, counts a per-slot respawn delay in frames after collection, and round-robin arbitrates ready slots. For the granted slot it picks a platform and an on-platform x position, then offers the spawn over a valid/ready handshake to the egg sprite units. It sits between the yoshi/egg collision logic and the egg sprite/score blocks.

## Interface
- NUM_SLOTS, 4: egg slots managed (2..8).
- RESPAWN_FRAMES, 30: frame ticks between collection and respawn eligibility (0..63).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- collect  in  NUM_SLOTS  per-slot one-cycle pulse: yoshi collided with that slot's egg.
- spawn_ready  in  1  sprite units accept the offered spawn this cycle.
- spawn_valid  out  1  spawn offer present.
- spawn_slot  out  3  slot being spawned.
- spawn_x  out  10  egg x (upper-left).
- spawn_y  out  10  egg y (upper-left).
- spawn_type  out  6  egg type code (sprite/score lookup).
- active  out  NUM_SLOTS  slot holds a live egg.

## Operation
- Platform table (index: x range, y): 0 A [16,144] 116; 1 B [480,608] 116; 2 C [80,545] 199; 3 D [16,240] 282; 4 E [384,608] 282; 5 F [112,513] 365; 6 G [16,608] 448.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, shifts every clock. pos_cnt: 10-bit free-running, +1 per clock, wraps 1023->0, reset 0.
- Per slot: active bit, pending bit, 6-bit countdown.
- collect[i] with active[i]=1: clear active[i], set pending[i], load countdown = RESPAWN_FRAMES. collect[i] with active[i]=0 is ignored.
- frame_tick decrements every nonzero countdown of pending slots. A slot is ready when pending=1 and countdown=0.
- Round-robin pointer: the search starts at the slot after the last granted slot. After reset, search starts at slot 0.
- FSM states and transitions:
  - IDLE: if any slot is ready, grant the first ready slot, go to PICK.
  - PICK: latch plat = LFSR[2:0] (7 maps to 6), off = pos_cnt, type = pos_cnt[5:0], tries = 0. Go to CHECK.
  - CHECK: if any active slot's stored platform equals plat and tries < 6, set plat = (plat+1) mod 7, tries+1, and stay in CHECK. Otherwise compute x, y and go to OFFER.
  - OFFER: spawn_valid = 1 with all outputs held stable. On spawn_ready: set active[slot], store plat for the slot, clear pending, update the pointer, go to IDLE.
- x computation: 11-bit sum s = lo + off. If s > hi, x = hi - off[6:0]; otherwise x = s[9:0]. The minimum span is 128, so x always falls in [lo, hi]. y comes from the table.
- Reset state: all slots pending with countdown 0 and active 0, so the initial eggs spawn back-to-back.

## Timing
- Reset values: spawn_valid=0, spawn_slot=0, spawn_x=0, spawn_y=0, spawn_type=0, active=0, FSM=IDLE.
- All outputs are registered.
- Ready slot to spawn_valid: 3 cycles minimum (IDLE→PICK→CHECK→OFFER), plus one cycle per CHECK retry, with at most 6 retries.
- Handshake completes in the cycle where spawn_valid and spawn_ready are both high. spawn_valid deasserts the next cycle, and active[slot] is visible the next cycle.
- At most one spawn per 4 cycles. There is no back-to-back offer.
- Simultaneous collect on multiple slots: all are accepted in the same cycle.
- collect and frame_tick in the same cycle: the countdown loads RESPAWN_FRAMES and does not decrement.
- RESPAWN_FRAMES=0: the slot is ready the cycle after collect.
- Reset asserted mid-OFFER: spawn_valid=0 on the next edge, and all state returns to reset values.

## Test plan
- Reset release, spawn_ready tied 1: four offers for slots 0,1,2,3 in order. Each has a distinct platform while free platforms exist, and each x is within its platform range. active reaches 4'b1111.
- Collect slot 2 with RESPAWN_FRAMES=30: the offer for slot 2 appears 3 cycles after the 30th subsequent frame_tick. active[2]=0 throughout the delay.
- Collect slots 1 and 3 in the same cycle, last grant = slot 1: slot 3 is offered first, then slot 1.
- Hold spawn_ready=0 for 50 cycles during OFFER: spawn_valid, spawn_slot, spawn_x, spawn_y and spawn_type are stable. A collect for the offered slot is ignored.
- Force platform A with off=1000: s=1016 > 144, so x = 144 - (1000 & 127) = 144 - 104 = 40, y = 116.
- Assert reset during OFFER: spawn_valid=0 next cycle, active=0, and the initial spawn sequence restarts.
